// File: rtl/stack_pkg.sv
// Shared definitions for the 3-deep stack machine and its command issuer.
// Holds the opcode encoding used on both the client request port and the
// stack ctl bus, the issuer FSM state encoding, the error codes, and the
// default stack depth so both sides agree on a single value.
package stack_pkg;

    // ctl / req_op encoding
    localparam logic [1:0] OP_POP        = 2'b00;
    localparam logic [1:0] OP_PUSH_HALF  = 2'b01;
    localparam logic [1:0] OP_PUSH_FULL  = 2'b10;
    localparam logic [1:0] OP_PUSH_SPLIT = 2'b11;

    // err_code encoding
    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_OVERFLOW  = 2'b01;
    localparam logic [1:0] ERR_UNDERFLOW = 2'b10;

    // Default stack depth shared by the issuer and the stack machine
    localparam int STACK_SIZE_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_ISSUE    = 2'b01,
        ST_WAIT_RSP = 2'b10
    } state_t;

endpackage

// File: rtl/stack_occ_tracker.sv
// Occupancy tracker for the stack command issuer.
// Mirrors the stack's fill level in a registered counter and judges, purely
// combinationally, whether an incoming opcode fits.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   chk_op     opcode being offered by the client (checked every cycle)
//   upd        pulse: a command has been issued this cycle, apply it to occ
//   upd_op     opcode of the command being issued
//   occ        current occupancy, 0..STACK_SIZE
//   legal      chk_op can be issued at the current occupancy
//   err_code   reason chk_op is illegal (ERR_NONE when legal)
module stack_occ_tracker
    import stack_pkg::*;
#(
    parameter int STACK_SIZE = STACK_SIZE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] chk_op,
    input  logic       upd,
    input  logic [1:0] upd_op,
    output logic [1:0] occ,
    output logic       legal,
    output logic [1:0] err_code
);

    // Comparisons are done one bit wider so occ+2 cannot wrap.
    localparam logic [2:0] SIZE_X = 3'(STACK_SIZE);

    logic [2:0] occ_x;
    assign occ_x = {1'b0, occ};

    always_comb begin
        legal    = 1'b0;
        err_code = ERR_NONE;
        case (chk_op)
            OP_POP:        legal = (occ != 2'd0);
            OP_PUSH_SPLIT: legal = ((occ_x + 3'd2) <= SIZE_X);
            default:       legal = (occ_x < SIZE_X);
        endcase
        if (!legal) begin
            err_code = (chk_op == OP_POP) ? ERR_UNDERFLOW : ERR_OVERFLOW;
        end
    end

    // Only legal commands are ever issued, so occ cannot leave 0..STACK_SIZE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ <= 2'd0;
        end else if (upd) begin
            case (upd_op)
                OP_POP:        occ <= occ - 2'd1;
                OP_PUSH_SPLIT: occ <= occ + 2'd2;
                default:       occ <= occ + 2'd1;
            endcase
        end
    end

    a_occ_bound: assert property (@(posedge clk) disable iff (rst) occ_x <= SIZE_X);

endmodule

// File: rtl/stack_cmd_issuer.sv
// Command issuer for the 3-deep stack machine.
// Accepts one client request at a time on a valid/ready handshake, rejects
// requests that would overflow or underflow the stack, drives ctl/DATA_out
// for exactly one cycle per accepted command and returns popped words on a
// one-cycle response strobe.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   req_valid/req_ready   client handshake; req_op/req_data carry the request
//   rsp_valid/rsp_data    one-cycle pulse with the popped word (data held)
//   err_valid/err_code    one-cycle pulse on a rejected request
//   occ                   current stack occupancy
//   cmd_valid/ctl/DATA_out  command toward the stack (ctl=00 when idle)
//   i_wait                stack o_wait; blocks acceptance only
//   DATA_in               stack DATA_out, sampled RSP_LAT cycles after a pop
module stack_cmd_issuer
    import stack_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int STACK_SIZE = STACK_SIZE_DEF,
    parameter int RSP_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  err_valid,
    output logic [1:0]            err_code,
    output logic [1:0]            occ,
    output logic                  cmd_valid,
    output logic [1:0]            ctl,
    output logic [DATA_WIDTH-1:0] DATA_out,
    input  logic                  i_wait,
    input  logic [DATA_WIDTH-1:0] DATA_in
);

    // RSP_LAT is limited to 1..3, so two bits cover the wait counter.
    localparam int             CNT_W    = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RSP_LAT - 1);

    state_t           state;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             accept;
    logic             legal;
    logic [1:0]       chk_err;
    logic             issuing;

    assign req_ready = (state == ST_IDLE) && !i_wait;
    assign accept    = req_valid && req_ready;
    assign issuing   = (state == ST_ISSUE);

    stack_occ_tracker #(
        .STACK_SIZE (STACK_SIZE)
    ) u_occ (
        .clk      (clk),
        .rst      (rst),
        .chk_op   (req_op),
        .upd      (issuing),
        .upd_op   (op_q),
        .occ      (occ),
        .legal    (legal),
        .err_code (chk_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            op_q      <= OP_POP;
            wait_cnt  <= '0;
            cmd_valid <= 1'b0;
            ctl       <= OP_POP;
            DATA_out  <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            err_valid <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            // Strobes and the command bus are single-cycle by default;
            // DATA_out and rsp_data deliberately hold.
            rsp_valid <= 1'b0;
            err_valid <= 1'b0;
            err_code  <= ERR_NONE;
            cmd_valid <= 1'b0;
            ctl       <= OP_POP;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (legal) begin
                            // Outputs are registered, so the command appears
                            // on the bus during the ISSUE cycle itself.
                            op_q      <= req_op;
                            DATA_out  <= req_data;
                            cmd_valid <= 1'b1;
                            ctl       <= req_op;
                            state     <= ST_ISSUE;
                        end else begin
                            err_valid <= 1'b1;
                            err_code  <= chk_err;
                        end
                    end
                end
                ST_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= (op_q == OP_POP) ? ST_WAIT_RSP : ST_IDLE;
                end
                ST_WAIT_RSP: begin
                    if (wait_cnt == CNT_LAST) begin
                        rsp_data  <= DATA_in;
                        rsp_valid <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_cmd_issuer.sv
// Testbench for stack_cmd_issuer: table of requests with expected outcome,
// scoreboard queues for pop responses and error pulses, plus hand-written
// sequences for i_wait back-pressure and reset during a pending pop.
module tb_stack_cmd_issuer;

    localparam int DW      = 32;
    localparam int RSP_LAT = 1;

    localparam logic [1:0] P_POP   = 2'b00;
    localparam logic [1:0] P_HALF  = 2'b01;
    localparam logic [1:0] P_FULL  = 2'b10;
    localparam logic [1:0] P_SPLIT = 2'b11;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [DW-1:0] req_data;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          err_valid;
    logic [1:0]    err_code;
    logic [1:0]    occ;
    logic          cmd_valid;
    logic [1:0]    ctl;
    logic [DW-1:0] DATA_out;
    logic          i_wait;
    logic [DW-1:0] DATA_in;
    logic [DW-1:0] pop_val;

    int n_checks;
    int n_errs;

    logic [31:0] sb_rsp[$];
    logic [1:0]  sb_err[$];
    logic [31:0] last_rsp;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        bit          legal;
        logic [1:0]  err;
        logic [1:0]  occ;
        logic [31:0] pv;
    } vec_t;

    vec_t vecs[$];

    stack_cmd_issuer #(
        .DATA_WIDTH (DW),
        .STACK_SIZE (3),
        .RSP_LAT    (RSP_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .err_valid (err_valid),
        .err_code  (err_code),
        .occ       (occ),
        .cmd_valid (cmd_valid),
        .ctl       (ctl),
        .DATA_out  (DATA_out),
        .i_wait    (i_wait),
        .DATA_in   (DATA_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stack model: a pop seen on the bus presents its word one cycle later.
    always @(posedge clk) begin
        DATA_in <= (cmd_valid && ctl == P_POP) ? pop_val : 32'h0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard side: compare every response / error pulse against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid) begin
                if (sb_rsp.size() == 0) check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                else check("rsp_data", rsp_data, sb_rsp.pop_front());
            end
            if (err_valid) begin
                if (sb_err.size() == 0) check("err_unexpected", 32'(err_valid), 32'd0);
                else check("err_code", 32'(err_code), 32'(sb_err.pop_front()));
            end
        end
    end

    task automatic do_req(input vec_t v);
        int k;
        logic [1:0] occ0;
        occ0 = occ;
        if (v.legal && v.op == P_POP) begin
            sb_rsp.push_back(v.pv);
            pop_val = v.pv;
        end
        if (!v.legal) sb_err.push_back(v.err);
        req_valid = 1'b1;
        req_op    = v.op;
        req_data  = v.data;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("req_ready_wait", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        if (v.legal) begin
            check("issue_cmd_valid", 32'(cmd_valid), 32'd1);
            check("issue_ctl", 32'(ctl), 32'(v.op));
            check("issue_data", DATA_out, v.data);
            check("issue_ready_low", 32'(req_ready), 32'd0);
            if (v.op != P_POP) begin
                @(negedge clk);
                check("push_occ", 32'(occ), 32'(v.occ));
                check("push_cmd_off", 32'(cmd_valid), 32'd0);
                check("push_ctl_off", 32'(ctl), 32'd0);
                check("push_ready_back", 32'(req_ready), 32'd1);
                check("push_data_hold", DATA_out, v.data);
                check("rsp_data_hold", rsp_data, last_rsp);
            end else begin
                k = 1;
                while (!rsp_valid && k < 20) begin
                    @(negedge clk);
                    k++;
                end
                check("pop_latency", 32'(k), 32'(2 + RSP_LAT));
                check("pop_occ", 32'(occ), 32'(v.occ));
                check("pop_ctl_off", 32'(ctl), 32'd0);
                last_rsp = v.pv;
            end
        end else begin
            check("rej_err_valid", 32'(err_valid), 32'd1);
            check("rej_cmd_valid", 32'(cmd_valid), 32'd0);
            check("rej_ctl", 32'(ctl), 32'd0);
            check("rej_occ", 32'(occ), 32'(occ0));
            check("rej_occ_exp", 32'(occ), 32'(v.occ));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_occ"}, 32'(occ), 32'd0);
        check({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
        check({tag, "_ctl"}, 32'(ctl), 32'd0);
        check({tag, "_data_out"}, DATA_out, 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_data"}, rsp_data, 32'd0);
        check({tag, "_err_valid"}, 32'(err_valid), 32'd0);
        check({tag, "_err_code"}, 32'(err_code), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_errs    = 0;
        last_rsp  = 32'h0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_data  = 32'h0;
        i_wait    = 1'b0;
        pop_val   = 32'h0;

        //             op       data          legal err    occ   pop word
        vecs.push_back('{P_FULL,  32'hDEADBEEF, 1'b1, 2'b00, 2'd1, 32'h0});
        vecs.push_back('{P_POP,   32'h0,        1'b1, 2'b00, 2'd0, 32'hCAFEF00D});
        vecs.push_back('{P_FULL,  32'h00000011, 1'b1, 2'b00, 2'd1, 32'h0});
        vecs.push_back('{P_HALF,  32'h12345678, 1'b1, 2'b00, 2'd2, 32'h0});
        vecs.push_back('{P_FULL,  32'h00000033, 1'b1, 2'b00, 2'd3, 32'h0});
        vecs.push_back('{P_FULL,  32'h00000044, 1'b0, 2'b01, 2'd3, 32'h0});
        vecs.push_back('{P_SPLIT, 32'h00000005, 1'b0, 2'b01, 2'd3, 32'h0});
        vecs.push_back('{P_POP,   32'h0,        1'b1, 2'b00, 2'd2, 32'h01010101});
        vecs.push_back('{P_POP,   32'h0,        1'b1, 2'b00, 2'd1, 32'h02020202});
        vecs.push_back('{P_POP,   32'h0,        1'b1, 2'b00, 2'd0, 32'h03030303});
        vecs.push_back('{P_POP,   32'h0,        1'b0, 2'b10, 2'd0, 32'h0});
        vecs.push_back('{P_FULL,  32'h00000055, 1'b1, 2'b00, 2'd1, 32'h0});
        vecs.push_back('{P_SPLIT, 32'hAAAA5555, 1'b1, 2'b00, 2'd3, 32'h0});
        vecs.push_back('{P_POP,   32'h0,        1'b1, 2'b00, 2'd2, 32'h0BEEF000});
        vecs.push_back('{P_SPLIT, 32'h00000066, 1'b0, 2'b01, 2'd2, 32'h0});
        vecs.push_back('{P_POP,   32'h0,        1'b1, 2'b00, 2'd1, 32'h12121212});

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        #1 check("ready_after_reset", 32'(req_ready), 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            do_req(vecs[i]);
        end

        // Back-pressure: i_wait blocks acceptance entirely
        @(negedge clk);
        i_wait    = 1'b1;
        req_valid = 1'b1;
        req_op    = P_FULL;
        req_data  = 32'h99999999;
        #1 check("iwait_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("iwait_ready_hold", 32'(req_ready), 32'd0);
            check("iwait_no_cmd", 32'(cmd_valid), 32'd0);
            check("iwait_occ", 32'(occ), 32'd1);
        end
        req_valid = 1'b0;
        i_wait    = 1'b0;
        #1 check("iwait_release", 32'(req_ready), 32'd1);

        // Reset while a pop response is pending: nothing must come out
        @(negedge clk);
        pop_val   = 32'h77777777;
        req_valid = 1'b1;
        req_op    = P_POP;
        req_data  = 32'h0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rstpop_issue", 32'(cmd_valid), 32'd1);
        @(negedge clk);
        check("rstpop_waiting", 32'(req_ready), 32'd0);
        rst = 1'b1;
        #1 check_all_zero("rst_mid_wait");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 check("rstpop_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rstpop_no_rsp", 32'(rsp_valid), 32'd0);
        end
        check("rstpop_occ", 32'(occ), 32'd0);

        check("sb_rsp_drained", 32'(sb_rsp.size()), 32'd0);
        check("sb_err_drained", 32'(sb_err.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
